shift_seq: RTL



---
 rtl/shift_seq_pkg.sv | 15 +
 rtl/shift_seq_step.sv | 22 ++
 rtl/shift_seq.sv | 90 +++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the iterative shifter: operation codes and FSM states.
package shift_seq_pkg;

    // Op encoding used by the execute stage.
    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage : shift_seq_pkg

// File: rtl/shift_seq_step.sv
// One-bit shift/rotate stage; sits in the feedback path from the Out register.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] d_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] q_o
);

    // Select the single-step transform for the requested operation.
    always_comb begin
        case (op_i)
            OP_ROL:  q_o = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
            OP_SLL:  q_o = {d_i[WIDTH-2:0], 1'b0};
            OP_SRA:  q_o = {d_i[WIDTH-1], d_i[WIDTH-1:1]};
            default: q_o = {1'b0, d_i[WIDTH-1:1]};
        endcase
    end

endmodule : shift_step

// File: rtl/shift_seq.sv
// Iterative 16-bit shifter/rotator: loads an operand, then applies one
// one-bit step per clock until the requested count is consumed.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    input  logic [1:0]       Op,
    output logic [WIDTH-1:0] Out,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       op_q,    op_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic [WIDTH-1:0] step_out;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .d_i  (out_q),
        .op_i (op_q),
        .q_o  (step_out)
    );

    // Next-state logic: accept starts in IDLE/DONE, step while in SHIFT.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        out_d   = out_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    out_d   = In;
                    cnt_d   = Cnt;
                    op_d    = Op;
                    state_d = (Cnt == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Abort freezes Out at its partial value and outranks any start.
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    out_d = step_out;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, count, op and working registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_ROL;
            out_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            out_q   <= out_d;
        end
    end

    assign Out  = out_q;
    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);

endmodule : shift_seq
